// File: rtl/vga_pkg.sv
// vga_pkg
// Constants, the stage-1 pipeline record, and helpers shared by the
// character renderer and its glyph ROM. The digit font is an 8x8 bitmap
// with row 0 in the top byte and the leftmost pixel in the MSB of each row.
package vga_pkg;

    localparam int ACTIVE_W          = 480;
    localparam int ACTIVE_H          = 272;
    localparam int GLYPH_SCALE_SHIFT = 4;
    localparam int NUM_CHARS         = 10;
    localparam int PIPE_LAT          = 2;
    localparam int GLYPH_SPAN        = 8 << GLYPH_SCALE_SHIFT;

    typedef struct packed {
        logic       active;
        logic       in_box;
        logic [2:0] glyph_col;
        logic       hsync;
        logic       vsync;
    } stage1_t;

    function automatic logic [3:0] next_char(input logic [3:0] idx);
        return (idx == 4'(NUM_CHARS - 1)) ? 4'd0 : idx + 4'd1;
    endfunction

    function automatic logic [7:0] font_row(input logic [3:0] idx, input logic [2:0] row);
        logic [63:0] glyph;
        case (idx)
            4'd0:    glyph = 64'h3C66_6E76_6666_3C00;
            4'd1:    glyph = 64'h1838_1818_1818_7E00;
            4'd2:    glyph = 64'h3C66_060C_3060_7E00;
            4'd3:    glyph = 64'h3C66_061C_0666_3C00;
            4'd4:    glyph = 64'h0C1C_3C6C_7E0C_0C00;
            4'd5:    glyph = 64'h7E60_7C06_0666_3C00;
            4'd6:    glyph = 64'h3C60_7C66_6666_3C00;
            4'd7:    glyph = 64'h7E06_0C18_3030_3000;
            4'd8:    glyph = 64'h3C66_663C_6666_3C00;
            4'd9:    glyph = 64'h3C66_663E_060C_3800;
            default: glyph = '0;
        endcase
        return glyph[{3'd7 - row, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/char_rom.sv
// char_rom
// Registered digit glyph ROM, one-cycle read latency.
//   clk9MHz : pixel clock
//   rst     : asynchronous active-high reset, clears the read register
//   idx     : digit 0-9 (values above 9 read as blank)
//   row     : glyph row 0-7, top first
//   bits    : row bitmap, MSB is the leftmost pixel
module char_rom
    import vga_pkg::*;
(
    input  logic       clk9MHz,
    input  logic       rst,
    input  logic [3:0] idx,
    input  logic [2:0] row,
    output logic [7:0] bits
);

    always_ff @(posedge clk9MHz or posedge rst) begin
        if (rst) begin
            bits <= '0;
        end else begin
            bits <= font_row(idx, row);
        end
    end

endmodule

// File: rtl/vga_char_render.sv
// vga_char_render
// Draws one 8x8 digit, scaled x16, inside a coloured box on a 480x272
// display. The digit advances on clk3Hz rising edges, but only at end of
// frame so a glyph never tears.
//   clk9MHz, rst                  : pixel clock, async active-high reset
//   hSync, vSync, hData, vData    : timing from the sync generator
//   clk3Hz                        : character-advance toggle (same domain)
//   hSyncOut, vSyncOut, deOut     : timing delayed two cycles to match pixels
//   red, green, blue              : pixel colour
//   charIdx                       : digit currently displayed
module vga_char_render
    import vga_pkg::*;
#(
    parameter logic [23:0] FG_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB = 24'h0000FF,
    parameter int          BOX_X0 = 176,
    parameter int          BOX_Y0 = 72
) (
    input  logic       clk9MHz,
    input  logic       rst,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       hData,
    input  logic       vData,
    input  logic       clk3Hz,
    output logic       hSyncOut,
    output logic       vSyncOut,
    output logic       deOut,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [3:0] charIdx
);

    localparam logic [8:0] BOX_X = 9'(BOX_X0);
    localparam logic [8:0] BOX_Y = 9'(BOX_Y0);

    logic [8:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        hdata_q, vdata_q;
    logic        clk3_q, armed_q;
    logic        pending_q, pending_d;
    logic        synced_q;
    logic [3:0]  char_q, char_d;
    stage1_t     s1_q, s1_d;
    logic [7:0]  rom_bits;
    logic [23:0] rgb_q, rgb_d;
    logic        de_q, hs_q, vs_q;

    logic [8:0]  dx, dy;
    logic        h_fall, v_fall, c3_rise;
    logic        active, in_box;

    char_rom u_rom (
        .clk9MHz (clk9MHz),
        .rst     (rst),
        .idx     (char_q),
        .row     (dy[GLYPH_SCALE_SHIFT +: 3]),
        .bits    (rom_bits)
    );

    always_comb begin
        h_fall  = hdata_q & ~hData;
        v_fall  = vdata_q & ~vData;
        // armed_q masks the first cycle after reset so a clk3Hz that is
        // already high is not mistaken for a fresh edge.
        c3_rise = armed_q & clk3Hz & ~clk3_q;

        x_d = '0;
        if (hData) begin
            x_d = (x_q == 9'(ACTIVE_W - 1)) ? x_q : x_q + 9'd1;
        end

        y_d = '0;
        if (vData) begin
            y_d = y_q;
            if (h_fall && (y_q != 9'(ACTIVE_H - 1))) begin
                y_d = y_q + 9'd1;
            end
        end

        dx = x_q - BOX_X;
        dy = y_q - BOX_Y;

        // After a mid-frame reset the counters are meaningless until the
        // next vertical blank, so stay dark until then.
        active = hData & vData & synced_q;
        in_box = active && (x_q >= BOX_X) && (dx < 9'(GLYPH_SPAN))
                        && (y_q >= BOX_Y) && (dy < 9'(GLYPH_SPAN));

        s1_d           = '0;
        s1_d.active    = active;
        s1_d.in_box    = in_box;
        s1_d.glyph_col = dx[GLYPH_SCALE_SHIFT +: 3];
        s1_d.hsync     = hSync;
        s1_d.vsync     = vSync;

        pending_d = pending_q;
        char_d    = char_q;
        // An edge landing on the end-of-frame cycle is consumed directly.
        if (v_fall && (pending_q || c3_rise)) begin
            char_d    = next_char(char_q);
            pending_d = 1'b0;
        end else if (c3_rise) begin
            pending_d = 1'b1;
        end

        rgb_d = '0;
        if (s1_q.in_box) begin
            rgb_d = rom_bits[3'd7 - s1_q.glyph_col] ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk9MHz or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            hdata_q   <= 1'b0;
            vdata_q   <= 1'b0;
            clk3_q    <= 1'b0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
            synced_q  <= 1'b0;
            char_q    <= '0;
            s1_q      <= '0;
            rgb_q     <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hdata_q   <= hData;
            vdata_q   <= vData;
            clk3_q    <= clk3Hz;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            synced_q  <= synced_q | ~vData;
            char_q    <= char_d;
            s1_q      <= s1_d;
            rgb_q     <= rgb_d;
            de_q      <= s1_q.active;
            hs_q      <= s1_q.hsync;
            vs_q      <= s1_q.vsync;
        end
    end

    assign red      = rgb_q[23:16];
    assign green    = rgb_q[15:8];
    assign blue     = rgb_q[7:0];
    assign deOut    = de_q;
    assign hSyncOut = hs_q;
    assign vSyncOut = vs_q;
    assign charIdx  = char_q;

endmodule

// File: tb/tb_vga_char_render.sv
// Directed bench for vga_char_render. Frames are shortened (two-pixel lines)
// except for one long line per frame where pixels are inspected.
module tb_vga_char_render;

    localparam logic [23:0] FG    = 24'hFFFFFF;
    localparam logic [23:0] BG    = 24'h0000FF;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam int          HN    = 16384;

    logic       clk9MHz = 1'b0;
    logic       rst     = 1'b1;
    logic       hSync   = 1'b1;
    logic       vSync   = 1'b1;
    logic       hData   = 1'b0;
    logic       vData   = 1'b0;
    logic       clk3Hz  = 1'b0;
    logic       hSyncOut, vSyncOut, deOut;
    logic [7:0] red, green, blue;
    logic [3:0] charIdx;

    vga_char_render #(
        .FG_RGB (24'hFFFFFF),
        .BG_RGB (24'h0000FF),
        .BOX_X0 (176),
        .BOX_Y0 (72)
    ) dut (
        .clk9MHz  (clk9MHz),
        .rst      (rst),
        .hSync    (hSync),
        .vSync    (vSync),
        .hData    (hData),
        .vData    (vData),
        .clk3Hz   (clk3Hz),
        .hSyncOut (hSyncOut),
        .vSyncOut (vSyncOut),
        .deOut    (deOut),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .charIdx  (charIdx)
    );

    always #5 clk9MHz = ~clk9MHz;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int x_peak = 0;
    int y_peak = 0;

    logic [23:0] rgb_h  [0:HN-1];
    logic        de_h   [0:HN-1];
    logic        hso_h  [0:HN-1];
    logic        vso_h  [0:HN-1];
    logic [3:0]  cidx_h [0:HN-1];
    logic        hs_in  [0:HN-1];
    logic        vs_in  [0:HN-1];
    logic        hd_in  [0:HN-1];
    logic        vd_in  [0:HN-1];
    bit          c3_plan[0:HN-1];

    // Sample index k holds outputs produced by inputs driven at index k-2.
    task automatic step(input logic hs, input logic vs, input logic hd, input logic vd);
        @(posedge clk9MHz);
        #1;
        rgb_h[cyc]  = {red, green, blue};
        de_h[cyc]   = deOut;
        hso_h[cyc]  = hSyncOut;
        vso_h[cyc]  = vSyncOut;
        cidx_h[cyc] = charIdx;
        if (int'(dut.x_q) > x_peak) x_peak = int'(dut.x_q);
        if (int'(dut.y_q) > y_peak) y_peak = int'(dut.y_q);
        hSync  = hs;
        vSync  = vs;
        hData  = hd;
        vData  = vd;
        clk3Hz = c3_plan[cyc];
        hs_in[cyc] = hs;
        vs_in[cyc] = vs;
        hd_in[cyc] = hd;
        vd_in[cyc] = vd;
        cyc++;
    endtask

    // 4 blank cycles, `lines` lines (2 active + 2 blank cycles, except
    // long_line), then vData falls at index vf.
    task automatic run_frame(input int lines, input int long_line, input int long_len,
                             output int ls, output int vf);
        ls = -1;
        for (int i = 0; i < 4; i++) step(1'b1, (i < 2) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        for (int l = 0; l < lines; l++) begin
            int len;
            len = (l == long_line) ? long_len : 2;
            if (l == long_line) ls = cyc;
            for (int i = 0; i < len; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b1, 1'b0, 1'b1);
        end
        vf = cyc;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({red, green, blue} !== BLACK) begin
            errors++; $display("FAIL reset_rgb got %h exp %h", {red, green, blue}, BLACK);
        end
        checks++;
        if (deOut !== 1'b0) begin errors++; $display("FAIL reset_de got %b exp 0", deOut); end
        checks++;
        if (hSyncOut !== 1'b0) begin errors++; $display("FAIL reset_hso got %b exp 0", hSyncOut); end
        checks++;
        if (vSyncOut !== 1'b0) begin errors++; $display("FAIL reset_vso got %b exp 0", vSyncOut); end
        checks++;
        if (charIdx !== 4'd0) begin errors++; $display("FAIL reset_char got %0d exp 0", charIdx); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_latency();
        int fs, ls, vf;
        fs = cyc;
        run_frame(4, -1, 2, ls, vf);
        checks++;
        if (de_h[fs + 5] !== 1'b0) begin errors++; $display("FAIL lat_de_early got %b exp 0", de_h[fs + 5]); end
        checks++;
        if (de_h[fs + 6] !== 1'b1) begin errors++; $display("FAIL lat_de_rise got %b exp 1", de_h[fs + 6]); end
        for (int k = fs; k < cyc - 2; k++) begin
            checks++;
            if (hso_h[k + 2] !== hs_in[k]) begin
                errors++; $display("FAIL lat_hso at %0d got %b exp %b", k, hso_h[k + 2], hs_in[k]);
            end
            checks++;
            if (vso_h[k + 2] !== vs_in[k]) begin
                errors++; $display("FAIL lat_vso at %0d got %b exp %b", k, vso_h[k + 2], vs_in[k]);
            end
            checks++;
            if (de_h[k + 2] !== (hd_in[k] & vd_in[k])) begin
                errors++; $display("FAIL lat_de at %0d got %b exp %b", k, de_h[k + 2], hd_in[k] & vd_in[k]);
            end
        end
    endtask

    task automatic test_glyph();
        int fs, ls, vf;
        fs = cyc;
        run_frame(74, 72, 320, ls, vf);
        checks++;
        if (rgb_h[fs + 6] !== BLACK) begin errors++; $display("FAIL glyph_0_0 got %h exp %h", rgb_h[fs + 6], BLACK); end
        checks++;
        if (de_h[fs + 6] !== 1'b1) begin errors++; $display("FAIL glyph_0_0_de got %b exp 1", de_h[fs + 6]); end
        checks++;
        if (rgb_h[ls + 175 + 2] !== BLACK) begin errors++; $display("FAIL glyph_175 got %h exp %h", rgb_h[ls + 177], BLACK); end
        checks++;
        if (de_h[ls + 175 + 2] !== 1'b1) begin errors++; $display("FAIL glyph_175_de got %b exp 1", de_h[ls + 177]); end
        checks++;
        if (rgb_h[ls + 176 + 2] !== BG) begin errors++; $display("FAIL glyph_176 got %h exp %h", rgb_h[ls + 178], BG); end
        checks++;
        if (rgb_h[ls + 208 + 2] !== FG) begin errors++; $display("FAIL glyph_208 got %h exp %h", rgb_h[ls + 210], FG); end
        checks++;
        if (rgb_h[ls + 303 + 2] !== BG) begin errors++; $display("FAIL glyph_303 got %h exp %h", rgb_h[ls + 305], BG); end
        checks++;
        if (rgb_h[ls + 304 + 2] !== BLACK) begin errors++; $display("FAIL glyph_304 got %h exp %h", rgb_h[ls + 306], BLACK); end
    endtask

    task automatic test_counters();
        int ls, vf;
        x_peak = 0;
        y_peak = 0;
        run_frame(286, 0, 500, ls, vf);
        checks++;
        if (x_peak != 479) begin errors++; $display("FAIL cnt_x_peak got %0d exp 479", x_peak); end
        checks++;
        if (y_peak != 271) begin errors++; $display("FAIL cnt_y_peak got %0d exp 271", y_peak); end
    endtask

    task automatic test_advance();
        int fs, ls, vf;
        fs = cyc;
        c3_plan[fs + 8] = 1'b1;
        c3_plan[fs + 9] = 1'b1;
        run_frame(3, -1, 2, ls, vf);
        checks++;
        if (cidx_h[fs + 12] !== 4'd0) begin errors++; $display("FAIL adv_mid got %0d exp 0", cidx_h[fs + 12]); end
        checks++;
        if (cidx_h[vf] !== 4'd0) begin errors++; $display("FAIL adv_pre_fall got %0d exp 0", cidx_h[vf]); end
        checks++;
        if (cidx_h[vf + 1] !== 4'd1) begin errors++; $display("FAIL adv_post_fall got %0d exp 1", cidx_h[vf + 1]); end
        // Digit 1 row 0 is 0x18: columns 3 and 4 lit, column 2 dark.
        fs = cyc;
        run_frame(74, 72, 320, ls, vf);
        checks++;
        if (rgb_h[ls + 224 + 2] !== FG) begin errors++; $display("FAIL adv_glyph_224 got %h exp %h", rgb_h[ls + 226], FG); end
        checks++;
        if (rgb_h[ls + 208 + 2] !== BG) begin errors++; $display("FAIL adv_glyph_208 got %h exp %h", rgb_h[ls + 210], BG); end
        for (int n = 0; n < 9; n++) begin
            fs = cyc;
            c3_plan[fs + 8] = 1'b1;
            c3_plan[fs + 9] = 1'b1;
            run_frame(3, -1, 2, ls, vf);
            if (n == 7) begin
                checks++;
                if (cidx_h[vf + 1] !== 4'd9) begin errors++; $display("FAIL adv_nine got %0d exp 9", cidx_h[vf + 1]); end
            end
        end
        checks++;
        if (charIdx !== 4'd0) begin errors++; $display("FAIL adv_wrap got %0d exp 0", charIdx); end
    endtask

    task automatic test_coincidence();
        int fs, ls, vf;
        fs = cyc;
        c3_plan[fs + 16] = 1'b1;
        c3_plan[fs + 17] = 1'b1;
        run_frame(3, -1, 2, ls, vf);
        checks++;
        if (cidx_h[vf + 1] !== 4'd1) begin errors++; $display("FAIL coin_fall got %0d exp 1", cidx_h[vf + 1]); end
        run_frame(3, -1, 2, ls, vf);
        checks++;
        if (charIdx !== 4'd1) begin errors++; $display("FAIL coin_no_pending got %0d exp 1", charIdx); end
        fs = cyc;
        c3_plan[fs + 5]  = 1'b1;
        c3_plan[fs + 6]  = 1'b1;
        c3_plan[fs + 9]  = 1'b1;
        c3_plan[fs + 10] = 1'b1;
        c3_plan[fs + 13] = 1'b1;
        run_frame(3, -1, 2, ls, vf);
        checks++;
        if (charIdx !== 4'd2) begin errors++; $display("FAIL coin_triple got %0d exp 2", charIdx); end
        run_frame(3, -1, 2, ls, vf);
        checks++;
        if (charIdx !== 4'd2) begin errors++; $display("FAIL coin_triple_after got %0d exp 2", charIdx); end
    endtask

    task automatic test_reset_midline();
        int r, h;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (deOut !== 1'b1) begin errors++; $display("FAIL rstm_de_before got %b exp 1", deOut); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({deOut, hSyncOut, vSyncOut} !== 3'b000) begin
            errors++; $display("FAIL rstm_ctl got %b exp 000", {deOut, hSyncOut, vSyncOut});
        end
        checks++;
        if ({red, green, blue} !== BLACK) begin errors++; $display("FAIL rstm_rgb got %h exp %h", {red, green, blue}, BLACK); end
        checks++;
        if (charIdx !== 4'd0) begin errors++; $display("FAIL rstm_char got %0d exp 0", charIdx); end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        r = cyc;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = r; k < cyc; k++) begin
            checks++;
            if ((de_h[k] !== 1'b0) || (rgb_h[k] !== BLACK)) begin
                errors++; $display("FAIL rstm_dark at %0d got de %b rgb %h exp de 0 rgb 0", k, de_h[k], rgb_h[k]);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        h = cyc;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (de_h[h + 2] !== 1'b1) begin errors++; $display("FAIL rstm_resync_de got %b exp 1", de_h[h + 2]); end
        checks++;
        if (charIdx !== 4'd0) begin errors++; $display("FAIL rstm_char_after got %0d exp 0", charIdx); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glyph();
        test_counters();
        test_advance();
        test_coincidence();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_char_render.md
VGA_CHAR_RENDER -- requirements
Module: vga_char_render

Interface
REQ-001 SHALL have parameters: FG_RGB, default 24'hFFFFFF, glyph foreground colour; BG_RGB, default 24'h0000FF, box background colour; BOX_X0, default 176, box left column; BOX_Y0, default 72, box top line.
REQ-002 SHALL have ports: clk9MHz input 1, pixel clock (the only clock); rst input 1, reset (asynchronous, active-high).
REQ-003 SHALL have ports: hSync, vSync, hData, vData input 1 each, timing from the sync-pulse generator on the same clock; clk3Hz input 1, character-advance toggle, same clock domain.
REQ-004 SHALL have ports: hSyncOut, vSyncOut, deOut output 1 each, syncs and data enable delayed to align with pixels.
REQ-005 SHALL have ports: red, green, blue output 8 each, pixel colour; charIdx output 4, digit currently displayed.

Function
REQ-006 SHALL treat the active area as hData AND vData, nominally 480 columns x 272 lines.
REQ-007 SHALL hold column counter x (9 bits) at 0 while hData is low, and increment it once per cycle while hData is high; it saturates at 479.
REQ-008 SHALL hold line counter y (9 bits) at 0 while vData is low, and increment it on each hData falling edge while vData is high; it saturates at 271.
REQ-009 SHALL define the glyph box as x in [BOX_X0, BOX_X0+127] and y in [BOX_Y0, BOX_Y0+127]: an 8x8 glyph scaled x16, glyph row = (y-BOX_Y0)>>4, glyph column = (x-BOX_X0)>>4, MSB leftmost.
REQ-010 SHALL use a fixed pipeline of 2 cycles: stage 1 registers x, y, in-box flag, active flag and syncs; stage 2 registers the ROM row, selects the bit, and drives the outputs.
REQ-011 SHALL delay hSyncOut, vSyncOut and deOut by exactly 2 cycles relative to hSync, vSync and hData AND vData.
REQ-012 SHALL output colour as follows: in box with glyph bit 1 -> FG_RGB; in box with glyph bit 0 -> BG_RGB; active but outside box -> 24'h000000; inactive -> 24'h000000.
REQ-013 SHALL register clk3Hz and detect its rising edge (0->1); each edge sets a pending flag.
REQ-014 SHALL update charIdx only at the vData falling edge (end of frame) while pending is set: charIdx increments, wrapping 9->0, and pending clears. The glyph never changes mid-frame.
REQ-015 SHALL handle a clk3Hz rising edge coincident with the vData falling edge by incrementing charIdx immediately and leaving pending clear.
REQ-016 SHALL absorb multiple clk3Hz edges within one frame into a single increment.
REQ-017 SHALL accept hData rising while vData is low without a y increment, and produce black output.

Reset
REQ-018 SHALL, while rst is high, asynchronously clear x, y, pending, charIdx, all pipeline registers, and all outputs to 0.
REQ-019 SHALL, after a mid-frame rst deassertion, drive black and deOut=0 until the counters have resynchronised on the next vData low period, with no spurious charIdx change.

Structure
REQ-020 SHALL place the constants ACTIVE_W=480, ACTIVE_H=272, GLYPH_SCALE_SHIFT=4, NUM_CHARS=10 and PIPE_LAT=2 in the shared package vga_pkg.
REQ-021 SHALL contain one sub-module char_rom: registered, 1-cycle read; inputs idx[3:0] and row[2:0]; output bits[7:0]; digits 0-9; rows for idx>9 return 0.

Verification
REQ-022 SHALL cover reset: rst pulse mid-line -> all outputs 0 within the same cycle; charIdx=0 after release.
REQ-023 SHALL cover latency: hData rises at cycle N with vData high -> deOut rises at N+2; hSyncOut equals hSync delayed by 2 for the whole frame.
REQ-024 SHALL cover glyph: charIdx=0, pixel (x=176, y=72) -> colour equals FG_RGB or BG_RGB per ROM row 0 bit 7; pixel (x=0, y=0) -> 24'h000000 with deOut=1.
REQ-025 SHALL cover advance: clk3Hz toggled 0->1 mid-frame -> charIdx unchanged until the vData fall, then 1; ten advances -> charIdx wraps to 0.
REQ-026 SHALL cover coincidence: clk3Hz rise on the vData-fall cycle -> exactly one increment; three clk3Hz rises in one frame -> exactly one increment.
REQ-027 SHALL cover counters: a full frame of 525x286 -> x peaks at 479 and y peaks at 271, with no overflow.
